// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared stall-reason encoding, latency constants and defaults
package hazard_scoreboard_pkg;

    localparam int DEF_REG_COUNT = 32;
    localparam int DEF_REG_AW    = 5;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 6;

    typedef enum logic [1:0] {
        SR_NONE   = 2'd0,
        SR_DATA   = 2'd1,
        SR_JUMP   = 2'd2,
        SR_FREEZE = 2'd3
    } stall_reason_e;

endpackage

// File: rtl/hazard_scoreboard_reg_counter.sv
// sb_reg_counter: one register's forwarding countdown with load/decrement/hold/clear
module sb_reg_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // freeze holds, a new producer overrides, otherwise count down to zero
    always_comb begin
        cnt_d = hold ? cnt_q : load ? load_val : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
    end

    // countdown register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard driving the ID stall/bubble
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_COUNT  = DEF_REG_COUNT,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int MAX_LAT    = 7,
    parameter int JUMP_EXTRA = 1,
    parameter int CNT_W      = $clog2(MAX_LAT + JUMP_EXTRA + 1),
    parameter int PERF_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic                 id_reg_write,
    input  logic [CNT_W-1:0]     id_latency,
    input  logic                 id_is_jump,
    input  logic                 id_flush,
    input  logic                 ex_busy,
    output logic                 bubble_stop,
    output logic                 issue,
    output logic [1:0]           stall_reason,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic [PERF_W-1:0]    stall_cycles
);

    // every encodable index has a slot so out-of-range sources read as idle
    localparam int               NREG = 1 << REG_AW;
    localparam logic [CNT_W-1:0] JX   = CNT_W'(JUMP_EXTRA);
    localparam logic [CNT_W-1:0] MX   = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0]  cnt [NREG];
    logic [CNT_W-1:0]  c1, c2, load_val;
    logic              e1, e2, haz_n, haz_j, haz, ld_en;
    stall_reason_e     reason;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    // hazard detection, stall/issue decisions and the producer load value
    always_comb begin
        c1          = cnt[id_rs1];
        c2          = cnt[id_rs2];
        e1          = id_rs1_used && id_rs1 != '0;
        e2          = id_rs2_used && id_rs2 != '0;
        haz_n       = (e1 && c1 > JX) || (e2 && c2 > JX);
        haz_j       = (e1 && c1 != '0) || (e2 && c2 != '0);
        haz         = id_valid && (id_is_jump ? haz_j : haz_n);
        bubble_stop = ex_busy || (haz && !id_flush);
        issue       = id_valid && !bubble_stop && !id_flush;
        ld_en       = issue && id_reg_write && id_rd != '0;
        load_val    = (id_latency > MX ? MX : id_latency) + JX;
        reason      = ex_busy ? SR_FREEZE :
                      !(haz && !id_flush) ? SR_NONE :
                      (id_is_jump && !haz_n) ? SR_JUMP : SR_DATA;
    end

    assign stall_reason = reason;

    genvar r;
    for (r = 0; r < NREG; r++) begin : g_reg
        if (r == 0 || r >= REG_COUNT) begin : g_zero
            assign cnt[r] = '0;
        end else begin : g_cnt
            sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .hold     (ex_busy),
                .load     (ld_en && id_rd == REG_AW'(r)),
                .load_val (load_val),
                .cnt      (cnt[r])
            );
        end
    end

    for (r = 0; r < REG_COUNT; r++) begin : g_mask
        assign pending_mask[r] = cnt[r] != '0;
    end

    // saturating stall-cycle count
    always_comb begin
        stall_cycles_d = (bubble_stop && stall_cycles_q != '1) ? stall_cycles_q + PERF_W'(1) : stall_cycles_q;
    end

    // performance counter register
    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule
